// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared types and helpers for the program sequencer of the MC14500B-style
// 1-bit system.
//   seq_state_t : sequencer FSM states
//   op_field    : extract the opcode field from a program word
//   addr_field  : extract the address field from a program word
// The helpers take the word zero-extended to FIELD_W bits so that they can be
// reused by any parameterisation up to that width.
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } seq_state_t;

  localparam int FIELD_W = 64;

  // Low addr_w bits of the word.
  function automatic logic [FIELD_W-1:0] addr_field(
    input logic [FIELD_W-1:0] word,
    input int unsigned        addr_w
  );
    return word & ~({FIELD_W{1'b1}} << addr_w);
  endfunction

  // instr_w bits directly above the address field.
  function automatic logic [FIELD_W-1:0] op_field(
    input logic [FIELD_W-1:0] word,
    input int unsigned        addr_w,
    input int unsigned        instr_w
  );
    return (word >> addr_w) & ~({FIELD_W{1'b1}} << instr_w);
  endfunction

endpackage

// File: rtl/return_stack.sv
// -----------------------------------------------------------------------------
// return_stack
// Hardware subroutine return-address stack, implemented as a shift register so
// the top of stack is always entry 0 (no pointer arithmetic on the read path).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (level only)
//   clear       : synchronous empty (contents left as-is)
//   push, pop   : push push_data / discard top; never issued together
//   push_data   : return address to save
//   top         : current top-of-stack entry
//   level       : number of occupied entries
//   full, empty : level == STACK_DEPTH / level == 0
// A push while full and a pop while empty are ignored; the parent reports them.
// -----------------------------------------------------------------------------
module return_stack #(
  parameter  int STACK_DEPTH = 4,
  parameter  int ADDR_WIDTH  = 8,
  localparam int LVL_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top,
  output logic [LVL_W-1:0]      level,
  output logic                  full,
  output logic                  empty
);

  logic [ADDR_WIDTH-1:0] entries [STACK_DEPTH];

  assign full  = (level == LVL_W'(STACK_DEPTH));
  assign empty = (level == '0);
  assign top   = entries[0];

  // NOTE: storage carries no reset; only the level counter defines validity,
  // which keeps the array free of reset fan-out and RAM/SRL friendly.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      entries[0] <= push_data;
      for (int i = 1; i < STACK_DEPTH; i++) entries[i] <= entries[i-1];
    end else if (pop && !empty) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) entries[i] <= entries[i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (clear) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + LVL_W'(1);
    end else if (pop && !empty) begin
      level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
// Fetch/control unit for the MC14500B-style 1-bit system. Owns the program
// memory, program counter and return stack, and offers a handshaked
// program-load mode. Each instruction takes a FETCH and an EXEC cycle; the
// ICU's jmp/rtn/flag_f are sampled on the edge closing EXEC.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset (release is
//                      synchronised internally)
//   load_en          : level request for program-load mode
//   load_valid/ready : load handshake; load_data is the word written
//   run, halt        : start/resume pulse, stop request
//   jmp, rtn, flag_f : ICU flags for the instruction in EXEC (flag_f = halt)
//   instr            : current instruction word, instr_valid high in EXEC
//   pc               : address of the current/next instruction
//   stack_level      : occupied return-stack entries
//   running          : high in FETCH or EXEC
//   err_overflow     : sticky, push attempted on full stack
//   err_underflow    : sticky, pop attempted on empty stack
//   err_conflict     : sticky, jmp and rtn both high in EXEC
// -----------------------------------------------------------------------------
module program_sequencer
  import seq_pkg::*;
#(
  parameter  int ADDR_WIDTH        = 8,
  parameter  int INSTRUCTION_WIDTH = 4,
  parameter  int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter  int STACK_DEPTH       = 4,
  localparam int LVL_W             = $clog2(STACK_DEPTH + 1),
  localparam int MEM_DEPTH         = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  run,
  input  logic                  halt,
  input  logic                  jmp,
  input  logic                  rtn,
  input  logic                  flag_f,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [LVL_W-1:0]      stack_level,
  output logic                  running,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic                  err_conflict
);

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  seq_state_t            state, state_d;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] load_ptr;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic [ADDR_WIDTH-1:0] stack_top;
  logic                  stack_full, stack_empty;
  logic                  stack_push, stack_pop, stack_clear;
  logic                  mem_we, ptr_clear;
  logic                  set_ovf, set_unf, set_cfl;

  assign pc_inc      = pc + ADDR_WIDTH'(1);
  assign jump_target = ADDR_WIDTH'(addr_field(FIELD_W'(instr), ADDR_WIDTH));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all registers
  // see pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (load_en) state_d = LOAD;
               else if (run) state_d = FETCH;
      LOAD:    if (!load_en) state_d = IDLE;
      FETCH:   state_d = EXEC;
      EXEC:    if (flag_f || halt) state_d = HALT;
               else if (load_en)   state_d = LOAD;
               else                state_d = FETCH;
      HALT:    if (load_en) state_d = LOAD;
               else if (run) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    load_ready  = 1'b0;
    instr_valid = 1'b0;
    running     = 1'b0;
    mem_we      = 1'b0;
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    stack_clear = 1'b0;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    set_cfl     = 1'b0;
    pc_d        = pc;
    unique case (state)
      LOAD: begin
        load_ready = 1'b1;
        mem_we     = load_valid;
        // Leaving LOAD restarts the program from a clean call context.
        if (!load_en) begin
          pc_d        = '0;
          stack_clear = 1'b1;
        end
      end
      FETCH: running = 1'b1;
      EXEC: begin
        running     = 1'b1;
        instr_valid = 1'b1;
        pc_d        = pc_inc;
        if (jmp && rtn) begin
          set_cfl = 1'b1;
        end else if (jmp) begin
          // The jump is taken even when the return address cannot be saved.
          pc_d       = jump_target;
          stack_push = !stack_full;
          set_ovf    = stack_full;
        end else if (rtn) begin
          if (stack_empty) begin
            set_unf = 1'b1;
          end else begin
            pc_d      = stack_top;
            stack_pop = 1'b1;
          end
        end
      end
      default: ;
    endcase
    ptr_clear = (state_d == LOAD) && (state != LOAD);
  end

  // ---------------------------------------------------------------------------
  // Program memory: write port for loading, synchronous read in FETCH.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_ptr] <= load_data;
  end

  // instr only changes on the FETCH->EXEC edge, so it holds the previous word
  // throughout FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
    end else if (state == FETCH) begin
      instr <= mem[pc];
    end
  end

  // ---------------------------------------------------------------------------
  // PC, load pointer and sticky error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= '0;
      load_ptr      <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_conflict  <= 1'b0;
    end else begin
      pc <= pc_d;
      if (ptr_clear)   load_ptr <= '0;
      else if (mem_we) load_ptr <= load_ptr + ADDR_WIDTH'(1);
      if (set_ovf) err_overflow  <= 1'b1;
      if (set_unf) err_underflow <= 1'b1;
      if (set_cfl) err_conflict  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Return stack
  // ---------------------------------------------------------------------------
  return_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_return_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (stack_clear),
    .push      (stack_push),
    .pop       (stack_pop),
    .push_data (pc_inc),
    .top       (stack_top),
    .level     (stack_level),
    .full      (stack_full),
    .empty     (stack_empty)
  );

endmodule

// File: tb/tb_program_sequencer.sv
// -----------------------------------------------------------------------------
// tb_program_sequencer
// Directed bench for program_sequencer with default parameters
// (ADDR_WIDTH=8, 12-bit words, STACK_DEPTH=4). The bench plays the ICU:
// it raises jmp/rtn/flag_f during EXEC for chosen pc values.
// -----------------------------------------------------------------------------
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en, load_valid, load_ready;
  logic [11:0] load_data;
  logic        run, halt, jmp, rtn, flag_f;
  logic [11:0] instr;
  logic        instr_valid;
  logic [7:0]  pc;
  logic [2:0]  stack_level;
  logic        running, err_overflow, err_underflow, err_conflict;

  int checks   = 0;
  int failures = 0;

  logic [11:0] img [256];

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .run           (run),
    .halt          (halt),
    .jmp           (jmp),
    .rtn           (rtn),
    .flag_f        (flag_f),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .stack_level   (stack_level),
    .running       (running),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_conflict  (err_conflict)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"},    32'(pc), 32'h0);
    check({tag, "_instr"}, 32'(instr), 32'h0);
    check({tag, "_flags"},
          32'({instr_valid, running, load_ready, err_overflow, err_underflow, err_conflict}),
          32'h0);
    check({tag, "_level"}, 32'(stack_level), 32'h0);
  endtask

  // Waits (bounded) for EXEC, checks the presented word, applies ICU flags
  // for one closing edge and checks the resulting pc.
  task automatic exec_step(input string tag, input logic [7:0] exp_pc,
                           input logic j, input logic r, input logic f,
                           input logic [7:0] exp_next);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(instr_valid), 32'h1);
    check({tag, "_pc"},    32'(pc), 32'(exp_pc));
    check({tag, "_instr"}, 32'(instr), 32'(img[exp_pc]));
    jmp = j; rtn = r; flag_f = f;
    step();
    jmp = 1'b0; rtn = 1'b0; flag_f = 1'b0;
    check({tag, "_next"}, 32'(pc), 32'(exp_next));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Program image: every word defaults to 0x100|addr, with call targets
    // placed at the addresses used below.
    for (int a = 0; a < 256; a++) img[a] = 12'h100 | 12'(a);
    img[8'h00] = 12'hA05; img[8'h01] = 12'hB07; img[8'h02] = 12'h000;
    img[8'h03] = 12'hC40; img[8'h04] = 12'hC60; img[8'h60] = 12'hC61;
    img[8'h61] = 12'hC62; img[8'h62] = 12'hC63; img[8'h63] = 12'hC64;
    img[8'h0B] = 12'hC12; img[8'h13] = 12'h2FF;

    reset = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
    run = 1'b0; halt = 1'b0; jmp = 1'b0; rtn = 1'b0; flag_f = 1'b0;

    // ---- Reset state
    step(); step(); step();
    check_all_zero("reset");
    reset = 1'b1;
    step(); step(); step();
    check("idle_load_ready", 32'(load_ready), 32'h0);

    // ---- Short load of three words
    load_en = 1'b1;
    step();
    check("load_ready_in_load", 32'(load_ready), 32'h1);
    load_valid = 1'b1; load_data = 12'hA05; step();
    load_data = 12'hB07; step();
    load_data = 12'h000; step();
    load_valid = 1'b0; load_en = 1'b0;
    step();
    check("load_exit_ready", 32'(load_ready), 32'h0);
    check("load_exit_pc", 32'(pc), 32'h0);

    // ---- Run: FETCH/EXEC alternation over pc 0,1,2
    run = 1'b1; step(); run = 1'b0;
    check("f0_running", 32'(running), 32'h1);
    check("f0_valid", 32'(instr_valid), 32'h0);
    check("f0_instr_hold", 32'(instr), 32'h0);
    step();
    check("e0_valid", 32'(instr_valid), 32'h1);
    check("e0_instr", 32'(instr), 32'hA05);
    check("e0_pc", 32'(pc), 32'h0);
    step();
    check("f1_valid", 32'(instr_valid), 32'h0);
    check("f1_instr_hold", 32'(instr), 32'hA05);
    check("f1_pc", 32'(pc), 32'h1);
    step();
    check("e1_instr", 32'(instr), 32'hB07);
    step(); step();
    check("e2_instr", 32'(instr), 32'h000);
    check("e2_pc", 32'(pc), 32'h2);
    halt = 1'b1; step(); halt = 1'b0;
    check("halt_running", 32'(running), 32'h0);
    check("halt_pc", 32'(pc), 32'h3);

    // ---- Full image load (load_en has priority from HALT)
    load_en = 1'b1; step();
    check("reload_ready", 32'(load_ready), 32'h1);
    for (int a = 0; a < 256; a++) begin
      load_valid = 1'b1; load_data = img[a]; step();
    end
    load_valid = 1'b0; load_en = 1'b0; step();
    check("reload_pc", 32'(pc), 32'h0);
    run = 1'b1; step(); run = 1'b0;

    // ---- Call / return
    exec_step("s0", 8'h00, 1'b0, 1'b0, 1'b0, 8'h01);
    exec_step("s1", 8'h01, 1'b0, 1'b0, 1'b0, 8'h02);
    exec_step("s2", 8'h02, 1'b0, 1'b0, 1'b0, 8'h03);
    exec_step("call", 8'h03, 1'b1, 1'b0, 1'b0, 8'h40);
    check("call_level", 32'(stack_level), 32'h1);
    exec_step("ret", 8'h40, 1'b0, 1'b1, 1'b0, 8'h04);
    check("ret_level", 32'(stack_level), 32'h0);

    // ---- Overflow: five nested calls
    exec_step("n1", 8'h04, 1'b1, 1'b0, 1'b0, 8'h60);
    exec_step("n2", 8'h60, 1'b1, 1'b0, 1'b0, 8'h61);
    exec_step("n3", 8'h61, 1'b1, 1'b0, 1'b0, 8'h62);
    exec_step("n4", 8'h62, 1'b1, 1'b0, 1'b0, 8'h63);
    check("n4_level", 32'(stack_level), 32'h4);
    check("n4_ovf", 32'(err_overflow), 32'h0);
    exec_step("n5", 8'h63, 1'b1, 1'b0, 1'b0, 8'h64);
    check("n5_level", 32'(stack_level), 32'h4);
    check("n5_ovf", 32'(err_overflow), 32'h1);
    exec_step("u1", 8'h64, 1'b0, 1'b1, 1'b0, 8'h63);
    exec_step("u2", 8'h63, 1'b0, 1'b1, 1'b0, 8'h62);
    exec_step("u3", 8'h62, 1'b0, 1'b1, 1'b0, 8'h61);
    exec_step("u4", 8'h61, 1'b0, 1'b1, 1'b0, 8'h05);
    check("unwind_level", 32'(stack_level), 32'h0);
    check("unwind_unf", 32'(err_underflow), 32'h0);

    // ---- Underflow and conflict
    for (int a = 5; a < 9; a++)
      exec_step("seq", 8'(a), 1'b0, 1'b0, 1'b0, 8'(a + 1));
    exec_step("unf", 8'h09, 1'b0, 1'b1, 1'b0, 8'h0A);
    check("unf_flag", 32'(err_underflow), 32'h1);
    exec_step("cfl", 8'h0A, 1'b1, 1'b1, 1'b0, 8'h0B);
    check("cfl_flag", 32'(err_conflict), 32'h1);
    check("cfl_level", 32'(stack_level), 32'h0);

    // ---- Software halt and resume
    exec_step("c12", 8'h0B, 1'b1, 1'b0, 1'b0, 8'h12);
    exec_step("hf", 8'h12, 1'b0, 1'b0, 1'b1, 8'h13);
    check("hf_running", 32'(running), 32'h0);
    halt = 1'b1; step(); step(); halt = 1'b0;
    check("hf_still_halted", 32'(running), 32'h0);
    check("hf_pc_kept", 32'(pc), 32'h13);
    run = 1'b1; step(); run = 1'b0;

    // ---- PC wrap at the top of memory
    exec_step("resume", 8'h13, 1'b1, 1'b0, 1'b0, 8'hFF);
    check("resume_level", 32'(stack_level), 32'h2);
    exec_step("wrap", 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);

    // ---- Reset in the middle of EXEC, then confirm memory survived
    step();
    check("pre_rst_valid", 32'(instr_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("midrst");
    reset = 1'b1;
    step(); step(); step();
    run = 1'b1; step(); run = 1'b0;
    exec_step("post_rst", 8'h00, 1'b0, 1'b0, 1'b0, 8'h01);
    exec_step("post_rst1", 8'h01, 1'b0, 1'b0, 1'b0, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Parametrised next-generation fetch/control unit for the MC14500B-style 1-bit system. Owns program memory, program counter, a hardware return stack and a handshaked program-load mode.
- Presents one instruction per execute slot to the ICU and consumes its jmp/rtn/flag_f outputs.
- Replaces the free-running PC plus directly written program RAM with run/halt control, subroutine support and error reporting.

Parameters:
- ADDR_WIDTH, 8, program address width; program memory depth = 2**ADDR_WIDTH words.
- INSTRUCTION_WIDTH, 4, opcode field width.
- DATA_WIDTH, ADDR_WIDTH + INSTRUCTION_WIDTH, program word width; opcode = [DATA_WIDTH-1:ADDR_WIDTH], address field = [ADDR_WIDTH-1:0].
- STACK_DEPTH, 4, number of return-stack entries (>= 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  level request for program-load mode.
- load_valid  in  1  load word valid.
- load_ready  out  1  sequencer accepts a load word this cycle.
- load_data  in  DATA_WIDTH  program word to store.
- run  in  1  start/resume pulse.
- halt  in  1  stop request.
- jmp  in  1  ICU JMP flag for the current instruction.
- rtn  in  1  ICU RTN flag for the current instruction.
- flag_f  in  1  ICU NOPF flag; used as the software halt.
- instr  out  DATA_WIDTH  current instruction word.
- instr_valid  out  1  high exactly in the EXEC cycle.
- pc  out  ADDR_WIDTH  address of the current/next instruction.
- stack_level  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- running  out  1  high in FETCH or EXEC.
- err_overflow  out  1  sticky: push attempted while stack full.
- err_underflow  out  1  sticky: pop attempted while stack empty.
- err_conflict  out  1  sticky: jmp and rtn both high in EXEC.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; pc = 0; stack empty; all outputs 0; instr = 0.
  - Program memory contents are not cleared.
- States:
  - IDLE: load_en -> LOAD; else run -> FETCH.
  - LOAD: load_ready = 1. Each cycle with load_valid & load_ready writes load_data at the load pointer, then increments the pointer.
    - The pointer is cleared to 0 on entry to LOAD and wraps from 2**ADDR_WIDTH-1 to 0.
    - load_en deassert -> IDLE, with pc = 0 and the stack cleared; errors are kept.
  - FETCH: synchronous memory read of pc issued -> EXEC.
  - EXEC: instr = word at pc, instr_valid = 1. On the closing edge, jmp/rtn/flag_f are sampled and the next pc is computed:
    - jmp only: push pc+1 (mod 2**ADDR_WIDTH); pc = address field of instr.
      - Stack full: the jump is still taken, the push is dropped and err_overflow is set.
    - rtn only: pc = popped entry.
      - Stack empty: pc = pc+1 and err_underflow is set.
      - The skip-after-RTN semantics remain the ICU's job.
    - jmp & rtn: pc = pc+1, stack unchanged, err_conflict set.
    - Neither flag: pc = pc+1, wrapping to 0.
    - Next state:
      - flag_f or halt sampled high -> HALT, with the pc update still applied.
      - Else load_en -> LOAD.
      - Else -> FETCH.
  - HALT: running = 0; run -> FETCH, resuming at pc; load_en -> LOAD (load_en has priority over run).
- Timing:
  - Each instruction takes 2 cycles (FETCH, EXEC).
  - In FETCH, instr holds the previous value and instr_valid = 0.
- Requests in IDLE/HALT:
  - halt while IDLE/HALT: ignored.
  - run while LOAD: ignored.
- Errors clear only on reset.
- Reset mid-LOAD: the partially written memory is kept, and the pointer restarts at 0 on the next LOAD.

Decomposition:
- Package seq_pkg: seq_state_t enum (IDLE, LOAD, FETCH, EXEC, HALT) and helper functions op_field/addr_field.
- Sub-module return_stack:
  - Parameters: STACK_DEPTH, ADDR_WIDTH.
  - Ports: push, pop, push_data, top, level, full, empty.
  - Simultaneous push & pop is not issued by the parent.
- Program memory is an inferred synchronous-read array inside program_sequencer.

Test Plan:
- Load: after reset, hold load_en, stream words 0xA05, 0xB07, 0x000, then drop load_en and pulse run.
  - Required: load_ready = 1 only in LOAD.
  - Required: instr = 0xA05 with instr_valid pulses every 2nd cycle, pc sequence 0, 1, 2.
- Call/return: jmp at pc = 3 with address field 0x40, then rtn at 0x40.
  - Required: pc goes 0x40, stack_level 1 -> 0, then pc = 4.
- Overflow: STACK_DEPTH = 4, five nested jmps.
  - Required: fifth jump taken, stack_level stays 4, err_overflow = 1; four rtns unwind correctly.
- Underflow/conflict:
  - rtn on empty stack at pc = 9 -> pc = 10, err_underflow = 1.
  - jmp & rtn together -> pc+1, err_conflict = 1.
- Halt/resume:
  - flag_f high at pc = 0x12 -> HALT with pc = 0x13, running = 0.
  - run pulse -> next instr_valid shows the word at 0x13.
- Reset/wrap:
  - Execute at pc = 0xFF -> next pc = 0x00.
  - Assert reset mid-EXEC -> all outputs 0 immediately, state IDLE, memory intact.
